// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA scan path: default 640x480@60 timing,
//   derived line/frame totals, 12-bit colour field layout and the
//   colour-bar test pattern encoding.
//   Optional feature macro used by consumers: VGA_TEST_PATTERN_EN.
package vga_timing_pkg;

  // Default 640x480@60 timing (pixel clock 25 MHz)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_PIX_LAT  = 2;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W = 10;

  // Packed pixel layout {B[3:0], G[3:0], R[3:0]}
  localparam int COLOR_W = 12;
  localparam int CH_W    = 4;
  localparam int R_LSB   = 0;
  localparam int G_LSB   = 4;
  localparam int B_LSB   = 8;

  // Colour bars: 8 equal-width vertical bars across the active line
  localparam int NUM_BARS = 8;
  localparam int BAR_IDX_W = 3;

  // Timing-signal bundle carried through the latency-matching delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0};

  // Bar k: each channel full-scale or off by bit k[2] (B), k[1] (G), k[0] (R)
  function automatic logic [COLOR_W-1:0] bar_colour(input logic [BAR_IDX_W-1:0] k);
    return {{CH_W{k[2]}}, {CH_W{k[1]}}, {CH_W{k[0]}}};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
//   DEPTH-stage register pipeline with asynchronous active-high reset to
//   INIT on every stage. DEPTH = 0 degenerates to a plain wire.
//   Ports:
//     vga_clk  in           pixel clock
//     vga_rst  in           asynchronous active-high reset
//     din      in  [WIDTH]  value entering the pipe
//     dout     out [WIDTH]  value delayed by DEPTH clocks
module vga_delay_line #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             vga_clk,
  input  logic             vga_rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = vga_clk ^ vga_rst;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
//   Scan-side VGA controller. Runs the raster counters, requests pixels
//   from the page renderer via x_pos/y_pos, and re-aligns hs/vs/de/
//   frame_start with the renderer's fixed PIX_LAT-clock latency before
//   registering them with the colour for the DAC.
//   Optional feature: `define VGA_TEST_PATTERN_EN adds the test_en port and
//   an internal 8-bar colour pattern.
//   Ports:
//     vga_clk      in       pixel clock (25 MHz)
//     vga_rst      in       asynchronous active-high reset
//     pixel_data   in  [12] renderer pixel {B,G,R}, valid PIX_LAT clocks
//                           after the matching x_pos/y_pos
//     test_en      in       (VGA_TEST_PATTERN_EN only) select colour bars
//     x_pos, y_pos out [10] requested column/row, 0 outside active area
//     hs, vs       out      active-low syncs
//     de           out      data enable on visible pixels
//     r, g, b      out [4]  colour, forced black while de = 0
//     frame_start  out      one-clock pulse with pixel (0,0)
//   Pixel interface contract: no handshake. The renderer must present the
//   pixel for an address exactly PIX_LAT clocks after that address appears;
//   every clock carries one address and consumes one pixel.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int PIX_LAT  = VGA_PIX_LAT
) (
  input  logic               vga_clk,
  input  logic               vga_rst,
  input  logic [COLOR_W-1:0] pixel_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_en,
`endif
  output logic [CNT_W-1:0]   x_pos,
  output logic [CNT_W-1:0]   y_pos,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [CH_W-1:0]    r,
  output logic [CH_W-1:0]    g,
  output logic [CH_W-1:0]    b,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // ---------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  logic h_act;
  logic v_act;
  assign h_act = (hcnt < H_ACT_C);
  assign v_act = (vcnt < V_ACT_C);

  // Addresses are clamped to 0 in blanking so the renderer never sees an
  // out-of-page request.
  assign x_pos = h_act ? hcnt : '0;
  assign y_pos = v_act ? vcnt : '0;

  // ---------------------------------------------------------------
  // Raw timing, delayed to line up with pixel_data
  // ---------------------------------------------------------------
  sync_t sync_raw;
  sync_t sync_dly;

  always_comb begin
    sync_raw    = SYNC_IDLE;
    sync_raw.hs = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
    sync_raw.vs = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
    sync_raw.de = h_act && v_act;
    sync_raw.fs = h_act && v_act && (hcnt == '0) && (vcnt == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_PX = CNT_W'(H_ACTIVE / NUM_BARS);

  // Bar index travels with the sync bundle so the pattern uses the same
  // column the renderer would have been asked for.
  logic [CNT_W-1:0]     bar_div;
  logic [BAR_IDX_W-1:0] bar_raw;
  logic [BAR_IDX_W-1:0] bar_dly;

  assign bar_div = hcnt / BAR_PX;
  assign bar_raw = bar_div[BAR_IDX_W-1:0];

  vga_delay_line #(
    .WIDTH ($bits(sync_t) + BAR_IDX_W),
    .DEPTH (PIX_LAT),
    .INIT  ({SYNC_IDLE, {BAR_IDX_W{1'b0}}})
  ) u_delay (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .din     ({sync_raw, bar_raw}),
    .dout    ({sync_dly, bar_dly})
  );
`else
  vga_delay_line #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (PIX_LAT),
    .INIT  (SYNC_IDLE)
  ) u_delay (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .din     (sync_raw),
    .dout    (sync_dly)
  );
`endif

  // ---------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------
  logic [COLOR_W-1:0] colour_nxt;

  always_comb begin
    colour_nxt = '0;
    if (sync_dly.de) begin
`ifdef VGA_TEST_PATTERN_EN
      colour_nxt = test_en ? bar_colour(bar_dly) : pixel_data;
`else
      colour_nxt = pixel_data;
`endif
    end
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      hs          <= 1'b1;
      vs          <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      hs          <= sync_dly.hs;
      vs          <= sync_dly.vs;
      de          <= sync_dly.de;
      frame_start <= sync_dly.fs;
      r           <= colour_nxt[R_LSB +: CH_W];
      g           <= colour_nxt[G_LSB +: CH_W];
      b           <= colour_nxt[B_LSB +: CH_W];
    end
  end

endmodule
